// File: rtl/cga_vram_bridge.sv
// CPU-side bridge into the CGA framebuffer. Decodes ISA memory cycles in the
// framebuffer window, waits for the sequencer's CPU slot and performs one byte
// access on the shared video RAM bus, holding the ISA cycle until it is done.
module cga_vram_bridge #(
  parameter logic [19:0] FRAMEBUFFER_ADDR = 20'hB8000,
  parameter logic [4:0]  RAM_BASE         = 5'b00010,
  parameter bit          USE_BUS_WAIT     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] bus_a,
  input  logic        bus_memr_l,
  input  logic        bus_memw_l,
  input  logic        bus_aen,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        bus_rdy,
  input  logic        isa_op_enable,
  output logic [18:0] ram_a,
  input  logic [7:0]  ram_d_in,
  output logic [7:0]  ram_d_out,
  output logic        ram_we_l,
  output logic        ram_cpu_sel
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSlot,
    StAccess,
    StCapture,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] offset_q, offset_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        is_write_q, is_write_d;

  // Active-high strobe pipelines: s1/s2 synchronise, s3 holds the previous synced value.
  logic        memr_s1_q, memr_s2_q, memr_s3_q;
  logic        memr_s1_d, memr_s2_d, memr_s3_d;
  logic        memw_s1_q, memw_s2_q, memw_s3_q;
  logic        memw_s1_d, memw_s2_d, memw_s3_d;

  logic        mem_cs;
  logic        req;
  logic        accept;
  logic        busy;

  assign mem_cs = (bus_a[19:14] == FRAMEBUFFER_ADDR[19:14]) & ~bus_aen;
  assign req    = mem_cs & ((memr_s2_q & ~memr_s3_q) | (memw_s2_q & ~memw_s3_q));

  // Strobe synchroniser next-state.
  always_comb begin
    memr_s1_d = ~bus_memr_l;
    memr_s2_d = memr_s1_q;
    memr_s3_d = memr_s2_q;
    memw_s1_d = ~bus_memw_l;
    memw_s2_d = memw_s1_q;
    memw_s3_d = memw_s2_q;
  end

  // Access FSM next-state, request latching and RAM bus outputs.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    rdata_d     = rdata_q;
    ram_cpu_sel = 1'b0;
    ram_we_l    = 1'b1;
    ram_a       = {RAM_BASE, offset_q};
    ram_d_out   = wdata_q;
    busy        = 1'b0;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept     = 1'b1;
          offset_d   = bus_a[13:0];
          wdata_d    = bus_d;
          is_write_d = memw_s2_q;  // write wins when both strobes are active
          state_d    = StWaitSlot;
        end
      end
      StWaitSlot: begin
        busy = 1'b1;
        if (isa_op_enable) state_d = StAccess;
      end
      StAccess: begin
        busy        = 1'b1;
        ram_cpu_sel = 1'b1;
        if (is_write_q) begin
          ram_we_l = 1'b0;
          state_d  = StDone;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        busy        = 1'b1;
        ram_cpu_sel = 1'b1;
        rdata_d     = ram_d_in;
        state_d     = StDone;
      end
      StDone: begin
        // An aborted cycle already has its strobe released and falls straight through.
        if (!(is_write_q ? memw_s2_q : memr_s2_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      offset_q   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      memr_s1_q  <= 1'b0;
      memr_s2_q  <= 1'b0;
      memr_s3_q  <= 1'b0;
      memw_s1_q  <= 1'b0;
      memw_s2_q  <= 1'b0;
      memw_s3_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      memr_s1_q  <= memr_s1_d;
      memr_s2_q  <= memr_s2_d;
      memr_s3_q  <= memr_s3_d;
      memw_s1_q  <= memw_s1_d;
      memw_s2_q  <= memw_s2_d;
      memw_s3_q  <= memw_s3_d;
    end
  end

  // ISA-side outputs.
  always_comb begin
    bus_out = rdata_q;
    bus_dir = mem_cs & ~bus_memr_l;
    bus_rdy = USE_BUS_WAIT ? ~(busy | accept) : 1'b1;
  end

endmodule
